fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the combinational instruction memory in the single-cycle RISC-V datapath. Owns the program counter, drives the memory read address, captures the returned word with its PC into a small FIFO, and presents it to decode over a valid/ready handshake. Taken branches, `jal` and `jalr` from execute redirect the PC and flush all buffered instructions.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory and
// buffers {pc, instr} pairs for decode. Optional halt-on-zero-word behaviour under FETCH_HALT_EN.
module fetch_stage #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32,
    parameter int RESET_PC    = 0,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [INS_W-1:0]       dec_instr,
    output logic [INS_ADDRESS-1:0] dec_pc,
    output logic                   misalign_err,
    output logic                   halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = INS_ADDRESS + INS_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
`ifdef FETCH_HALT_EN
    localparam logic [1:0] HALTED = 2'd2;
`endif

    logic [1:0]             state;
    logic [INS_ADDRESS-1:0] pc;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ENT_W-1:0]       fifo_mem [DEPTH];
    logic [ENT_W-1:0]       head;

    logic pop;
    logic room;
    logic push;

    assign imem_ra   = pc;
    assign dec_valid = (count != '0);
    assign head      = fifo_mem[rd_ptr];

    // Head fields are masked while empty so the unreset storage never leaks to decode.
    assign dec_pc    = dec_valid ? head[ENT_W-1:INS_W] : '0;
    assign dec_instr = dec_valid ? head[INS_W-1:0]     : '0;

    assign pop  = dec_valid && dec_ready;
    assign room = (count < DEPTH_C) || pop;
    assign push = (state == FETCH) && !redirect_valid && room;

`ifdef FETCH_HALT_EN
    assign halted = (state == HALTED);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= INS_ADDRESS'(RESET_PC);
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle handshake; the target is word-aligned.
            state        <= FETCH;
            pc           <= {redirect_pc[INS_ADDRESS-1:2], 2'b00};
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            misalign_err <= |redirect_pc[1:0];
        end else begin
            misalign_err <= 1'b0;
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (push) begin
`ifdef FETCH_HALT_EN
                        if (imem_rd == '0) state <= HALTED;
                        else               pc    <= pc + INS_ADDRESS'(4);
`else
                        pc <= pc + INS_ADDRESS'(4);
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALTED: state <= HALTED;
`endif
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pc, imem_rd};
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, back-pressure, redirect, misalign, wrap, halt.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  imem_ra;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [8:0]  dec_pc;
    logic        misalign_err;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.INS_ADDRESS(9), .INS_W(32), .RESET_PC(0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_ra(imem_ra), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .misalign_err(misalign_err), .halted(halted)
    );

    // Memory image: word 0 is 0x00007033, 0x100-0x17F is unprogrammed (zero).
    function automatic logic [31:0] word(input logic [8:0] a);
        if (a == 9'd0)         return 32'h0000_7033;
        if (a[8:7] == 2'b10)   return 32'h0;
        return {16'hC0DE, 7'd0, a};
    endfunction

    assign imem_rd = word(imem_ra);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        check("rst_ra", 32'(imem_ra), 32'h0);
        check("rst_valid", 32'(dec_valid), 32'h0);
        check("rst_instr", dec_instr, 32'h0);
        check("rst_pc", 32'(dec_pc), 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // Reset release and steady streaming
        rst_n = 1'b1;
        step();
        check("e0_valid", 32'(dec_valid), 32'h0);
        step();
        check("e1_valid", 32'(dec_valid), 32'h1);
        check("e1_pc", 32'(dec_pc), 32'h0);
        check("e1_instr", dec_instr, 32'h0000_7033);
        step(); check("stream_pc4", 32'(dec_pc), 32'h4);
        check("stream_instr4", dec_instr, 32'hC0DE_0004);
        step(); check("stream_pc8", 32'(dec_pc), 32'h8);
        step(); check("stream_pc12", 32'(dec_pc), 32'hC);
        check("stream_valid", 32'(dec_valid), 32'h1);

        // Back-pressure from reset
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("bp_ra_frozen", 32'(imem_ra), 32'h8);
        check("bp_head", 32'(dec_pc), 32'h0);
        check("bp_valid", 32'(dec_valid), 32'h1);
        dec_ready = 1'b1;
        step(); check("bp_out4", 32'(dec_pc), 32'h4);
        check("bp_out4_valid", 32'(dec_valid), 32'h1);
        step(); check("bp_out8", 32'(dec_pc), 32'h8);
        check("bp_out8_valid", 32'(dec_valid), 32'h1);
        step(); check("bp_out12", 32'(dec_pc), 32'hC);

        // Fill FIFO to two entries, then redirect to 0x38 with a same-cycle handshake
        dec_ready = 1'b0;
        step(); step();
        check("fill_head", 32'(dec_pc), 32'hC);
        check("fill_ra", 32'(imem_ra), 32'h14);
        redirect_valid = 1'b1; redirect_pc = 9'h038; dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_bubble", 32'(dec_valid), 32'h0);
        check("rd_ra", 32'(imem_ra), 32'h38);
        check("rd_no_misalign", 32'(misalign_err), 32'h0);
        step();
        check("rd_valid", 32'(dec_valid), 32'h1);
        check("rd_pc", 32'(dec_pc), 32'h38);
        check("rd_instr", dec_instr, 32'hC0DE_0038);
        step(); check("rd_next", 32'(dec_pc), 32'h3C);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 9'h03A;
        step();
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(misalign_err), 32'h1);
        check("mis_ra", 32'(imem_ra), 32'h38);
        check("mis_bubble", 32'(dec_valid), 32'h0);
        step();
        check("mis_clear", 32'(misalign_err), 32'h0);
        check("mis_pc", 32'(dec_pc), 32'h38);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 9'h1FC;
        step();
        redirect_valid = 1'b0;
        check("wrap_bubble", 32'(dec_valid), 32'h0);
        step();
        check("wrap_top", 32'(dec_pc), 32'h1FC);
        check("wrap_ra", 32'(imem_ra), 32'h0);
        step();
        check("wrap_zero", 32'(dec_pc), 32'h0);
        check("wrap_instr", dec_instr, 32'h0000_7033);

        // Zero word handling
        redirect_valid = 1'b1; redirect_pc = 9'h100;
        step();
        redirect_valid = 1'b0;
        check("zw_bubble", 32'(dec_valid), 32'h0);
        step();
        check("zw_valid", 32'(dec_valid), 32'h1);
        check("zw_pc", 32'(dec_pc), 32'h100);
        check("zw_instr", dec_instr, 32'h0);
`ifdef FETCH_HALT_EN
        check("halt_set", 32'(halted), 32'h1);
        step();
        check("halt_drained", 32'(dec_valid), 32'h0);
        check("halt_hold", 32'(halted), 32'h1);
        step(); step();
        check("halt_no_push", 32'(dec_valid), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 9'h000;
        step();
        redirect_valid = 1'b0;
        check("halt_clear", 32'(halted), 32'h0);
        check("halt_bubble", 32'(dec_valid), 32'h0);
        step();
        check("halt_resume", 32'(dec_valid), 32'h1);
        check("halt_resume_pc", 32'(dec_pc), 32'h0);
`else
        check("zw_halted", 32'(halted), 32'h0);
        step();
        check("zw_next_valid", 32'(dec_valid), 32'h1);
        check("zw_next_pc", 32'(dec_pc), 32'h104);
`endif

        // Reset mid-operation drops a pending misaligned redirect
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 9'h03A;
        step();
        redirect_valid = 1'b0;
        check("mrst_ra", 32'(imem_ra), 32'h0);
        check("mrst_valid", 32'(dec_valid), 32'h0);
        check("mrst_misalign", 32'(misalign_err), 32'h0);
        check("mrst_halted", 32'(halted), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
